// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory access stage: control word, access sizes and FSM states.
package common;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic      mem_read;
    logic      mem_write;
    mem_size_e mem_size;
    logic      mem_sign;
    logic      reg_write;
    logic      mem_to_reg;
  } control_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    OUT    = 2'd3
  } stage_state_e;

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
    logic res;
    case (size)
      MEM_HALF: res = addr_lo[0];
      MEM_WORD: res = (addr_lo != 2'b00);
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// mem_lane_align: combinational store lane replication/byte enables and load extraction.
module mem_lane_align
  import common::*;
(
  input  mem_size_e   i_st_size,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  mem_size_e   i_ld_size,
  input  logic        i_ld_sign,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_data,
  output logic [31:0] o_ld_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: half accesses only honour a[1], word accesses ignore the low bits.
  always_comb begin
    o_st_be    = 4'b0000;
    o_st_wdata = 32'h0000_0000;
    case (i_st_size)
      MEM_BYTE: begin
        o_st_be    = 4'b0001 << i_st_addr_lo;
        o_st_wdata = {4{i_st_data[7:0]}};
      end
      MEM_HALF: begin
        o_st_be    = 4'b0011 << {i_st_addr_lo[1], 1'b0};
        o_st_wdata = {2{i_st_data[15:0]}};
      end
      MEM_WORD: begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_data;
      end
      default: begin
        o_st_be    = 4'b0000;
        o_st_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Load side lane select
  always_comb begin
    w_byte = 8'h00;
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_ld_data[7:0];
      2'd1:    w_byte = i_ld_data[15:8];
      2'd2:    w_byte = i_ld_data[23:16];
      2'd3:    w_byte = i_ld_data[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_ld_addr_lo[1]) begin
      w_half = i_ld_data[31:16];
    end else begin
      w_half = i_ld_data[15:0];
    end
  end

  // Load side sign/zero extension
  always_comb begin
    o_ld_result = 32'h0000_0000;
    case (i_ld_size)
      MEM_BYTE: o_ld_result = {{24{i_ld_sign & w_byte[7]}}, w_byte};
      MEM_HALF: o_ld_result = {{16{i_ld_sign & w_half[15]}}, w_half};
      MEM_WORD: o_ld_result = i_ld_data;
      default:  o_ld_result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: issues loads/stores to the data memory and holds a writeback payload.
// Optional misaligned-access trapping is enabled with MEM_STAGE_MISALIGN_CHECK_EN.
module mem_access_stage
  import common::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  control_type control_in,
  input  logic [31:0] alu_data,
  input  logic [31:0] memory_data,
  input  logic [31:0] program_counter,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output control_type wb_control,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc,
  output logic        misaligned
);

  stage_state_e r_state, w_next_state;
  control_type  r_ctrl, w_in_ctrl;
  logic [31:0]  r_alu, r_pc;
  logic         r_flushed;
  logic         w_transfer, w_is_mem, w_misalign;
  logic [3:0]   w_st_be;
  logic [31:0]  w_st_wdata, w_ld_result;

  assign ex_ready   = (r_state == IDLE);
  assign w_transfer = ex_valid && ex_ready && !flush;
  assign w_is_mem   = control_in.mem_read || control_in.mem_write;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  assign w_misalign = w_is_mem && is_misaligned(control_in.mem_size, alu_data[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // Trapped accesses must not write the register file.
  always_comb begin
    w_in_ctrl           = control_in;
    w_in_ctrl.reg_write = control_in.reg_write & ~w_misalign;
  end

  mem_lane_align u_lane (
    .i_st_size    (control_in.mem_size),
    .i_st_addr_lo (alu_data[1:0]),
    .i_st_data    (memory_data),
    .o_st_be      (w_st_be),
    .o_st_wdata   (w_st_wdata),
    .i_ld_size    (r_ctrl.mem_size),
    .i_ld_sign    (r_ctrl.mem_sign),
    .i_ld_addr_lo (r_alu[1:0]),
    .i_ld_data    (dmem_rdata),
    .o_ld_result  (w_ld_result)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a flushed load still waits for its rvalid before retiring.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_transfer) begin
          w_next_state = (w_is_mem && !w_misalign) ? REQ : OUT;
        end else begin
          w_next_state = IDLE;
        end
      end
      REQ: begin
        if (flush) begin
          w_next_state = IDLE;
        end else if (dmem_gnt) begin
          w_next_state = r_ctrl.mem_write ? OUT : WAIT_R;
        end else begin
          w_next_state = REQ;
        end
      end
      WAIT_R: begin
        if (dmem_rvalid) begin
          w_next_state = (r_flushed || flush) ? IDLE : OUT;
        end else begin
          w_next_state = WAIT_R;
        end
      end
      OUT: begin
        if (flush || wb_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = OUT;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Registered request and writeback outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= '0;
      r_alu      <= 32'h0000_0000;
      r_pc       <= 32'h0000_0000;
      r_flushed  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_wdata <= 32'h0000_0000;
      dmem_be    <= 4'b0000;
      wb_valid   <= 1'b0;
      wb_control <= '0;
      wb_data    <= 32'h0000_0000;
      wb_pc      <= 32'h0000_0000;
      misaligned <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_transfer) begin
            r_ctrl    <= w_in_ctrl;
            r_alu     <= alu_data;
            r_pc      <= program_counter;
            r_flushed <= 1'b0;
            if (w_next_state == REQ) begin
              dmem_req   <= 1'b1;
              dmem_we    <= control_in.mem_write;
              dmem_addr  <= {alu_data[31:2], 2'b00};
              dmem_be    <= w_st_be;
              dmem_wdata <= w_st_wdata;
            end else begin
              wb_valid   <= 1'b1;
              wb_control <= w_in_ctrl;
              wb_data    <= alu_data;
              wb_pc      <= program_counter;
              misaligned <= w_misalign;
            end
          end
        end
        REQ: begin
          if (flush || dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
          end
          if (w_next_state == OUT) begin
            wb_valid   <= 1'b1;
            wb_control <= r_ctrl;
            wb_data    <= r_alu;
            wb_pc      <= r_pc;
            misaligned <= 1'b0;
          end
        end
        WAIT_R: begin
          if (flush) begin
            r_flushed <= 1'b1;
          end
          if (w_next_state == OUT) begin
            wb_valid   <= 1'b1;
            wb_control <= r_ctrl;
            wb_data    <= w_ld_result;
            wb_pc      <= r_pc;
            misaligned <= 1'b0;
          end
        end
        OUT: begin
          if (w_next_state == IDLE) begin
            wb_valid   <= 1'b0;
            misaligned <= 1'b0;
          end
        end
        default: begin
          dmem_req <= 1'b0;
          wb_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;
  import common::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  control_type control_in = '0;
  logic [31:0] alu_data = 32'h0;
  logic [31:0] memory_data = 32'h0;
  logic [31:0] program_counter = 32'h0;
  logic        flush = 1'b0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  control_type wb_control;
  logic [31:0] wb_data, wb_pc;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .control_in(control_in), .alu_data(alu_data), .memory_data(memory_data),
    .program_counter(program_counter), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_control(wb_control),
    .wb_data(wb_data), .wb_pc(wb_pc), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic control_type mk(input logic rd, input logic wr, input mem_size_e sz,
                                     input logic sg, input logic rw);
    control_type c;
    c.mem_read   = rd;
    c.mem_write  = wr;
    c.mem_size   = sz;
    c.mem_sign   = sg;
    c.reg_write  = rw;
    c.mem_to_reg = rd;
    return c;
  endfunction

  task automatic drive(input control_type c, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] pc);
    ex_valid        = 1'b1;
    control_in      = c;
    alu_data        = a;
    memory_data     = d;
    program_counter = pc;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++; if ({dmem_req, dmem_we, wb_valid, misaligned, dmem_be} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000000", {dmem_req, dmem_we, wb_valid, misaligned, dmem_be});
    end
    checks++; if ({dmem_addr, dmem_wdata, wb_data, wb_pc} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", {dmem_addr, dmem_wdata, wb_data, wb_pc});
    end
    checks++; if (wb_control !== control_type'(7'h00)) begin
      errors++; $display("FAIL reset_wb_control got %h want 00", wb_control);
    end
    checks++; if (ex_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ex_ready got %b want 1", ex_ready);
    end
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nonmem;
    control_type c;
    c = mk(1'b0, 1'b0, MEM_WORD, 1'b0, 1'b1);
    wb_ready = 1'b1;
    drive(c, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_0080);
    tick();
    ex_valid = 1'b0;
    checks++; if ({wb_valid, dmem_req, ex_ready} !== 3'b100) begin
      errors++; $display("FAIL nonmem_flags got %b want 100", {wb_valid, dmem_req, ex_ready});
    end
    checks++; if (wb_data !== 32'h0000_1234 || wb_pc !== 32'h0000_0080) begin
      errors++; $display("FAIL nonmem_payload got %h/%h want 00001234/00000080", wb_data, wb_pc);
    end
    checks++; if (wb_control !== c) begin
      errors++; $display("FAIL nonmem_control got %h want %h", wb_control, c);
    end
    tick();
    checks++; if ({wb_valid, dmem_req, ex_ready} !== 3'b001) begin
      errors++; $display("FAIL nonmem_retire got %b want 001", {wb_valid, dmem_req, ex_ready});
    end
  endtask

  task automatic test_gnt_idle;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    checks++; if ({wb_valid, dmem_req, ex_ready} !== 3'b001) begin
      errors++; $display("FAIL gnt_idle got %b want 001", {wb_valid, dmem_req, ex_ready});
    end
  endtask

  task automatic test_store_byte;
    drive(mk(1'b0, 1'b1, MEM_BYTE, 1'b0, 1'b0), 32'h0000_0103, 32'h0000_00AB, 32'h0000_0084);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({dmem_req, dmem_we, wb_valid} !== 3'b110 || dmem_addr !== 32'h0000_0100 ||
                    dmem_be !== 4'b1000 || dmem_wdata !== 32'hABAB_ABAB) begin
        errors++; $display("FAIL store_byte_hold cyc%0d got req%b we%b v%b addr %h be %b wd %h want 1 1 0 00000100 1000 abababab",
                           i, dmem_req, dmem_we, wb_valid, dmem_addr, dmem_be, dmem_wdata);
      end
      if (i == 2) dmem_gnt = 1'b1;
      tick();
    end
    dmem_gnt = 1'b0;
    checks++; if ({dmem_req, wb_valid} !== 2'b01 || wb_data !== 32'h0000_0103 || wb_pc !== 32'h0000_0084) begin
      errors++; $display("FAIL store_byte_wb got req%b v%b %h %h want 0 1 00000103 00000084", dmem_req, wb_valid, wb_data, wb_pc);
    end
    tick();
    checks++; if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL store_byte_retire got %b want 0", wb_valid);
    end
  endtask

  task automatic test_store_half;
    drive(mk(1'b0, 1'b1, MEM_HALF, 1'b0, 1'b0), 32'h0000_0106, 32'h1234_BEEF, 32'h0000_0088);
    tick();
    ex_valid = 1'b0;
    checks++; if (dmem_addr !== 32'h0000_0104 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEF_BEEF) begin
      errors++; $display("FAIL store_half got %h %b %h want 00000104 1100 beefbeef", dmem_addr, dmem_be, dmem_wdata);
    end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    checks++; if (wb_valid !== 1'b1) begin
      errors++; $display("FAIL store_half_wb got %b want 1", wb_valid);
    end
    tick();
  endtask

  task automatic test_load(input mem_size_e sz, input logic sg, input logic [31:0] addr,
                           input logic [31:0] waddr, input logic [3:0] be,
                           input logic [31:0] rdata, input logic [31:0] expd);
    control_type c;
    c = mk(1'b1, 1'b0, sz, sg, 1'b1);
    drive(c, addr, 32'h0, 32'h0000_0090);
    tick();
    ex_valid = 1'b0;
    checks++; if ({dmem_req, dmem_we} !== 2'b10 || dmem_addr !== waddr || dmem_be !== be) begin
      errors++; $display("FAIL load_req got %b %h %b want 10 %h %b", {dmem_req, dmem_we}, dmem_addr, dmem_be, waddr, be);
    end
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    checks++; if ({dmem_req, wb_valid} !== 2'b00) begin
      errors++; $display("FAIL load_wait got %b want 00", {dmem_req, wb_valid});
    end
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_rvalid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_data !== expd || wb_control !== c) begin
      errors++; $display("FAIL load_data got v%b %h ctl %h want 1 %h ctl %h", wb_valid, wb_data, wb_control, expd, c);
    end
    tick();
  endtask

  task automatic test_flush_wait_r;
    drive(mk(1'b1, 1'b0, MEM_BYTE, 1'b0, 1'b1), 32'h0000_0100, 32'h0, 32'h0000_00A0);
    tick();
    ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(mk(1'b0, 1'b0, MEM_WORD, 1'b0, 1'b1), 32'h0000_0077, 32'h0, 32'h0000_00A4);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({ex_ready, wb_valid} !== 2'b00) begin
        errors++; $display("FAIL flush_wait_hold cyc%0d got %b want 00", i, {ex_ready, wb_valid});
      end
      tick();
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0011;
    tick();
    dmem_rvalid = 1'b0;
    checks++; if ({ex_ready, wb_valid} !== 2'b10) begin
      errors++; $display("FAIL flush_wait_drop got %b want 10", {ex_ready, wb_valid});
    end
    tick();
    ex_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0000_0077) begin
      errors++; $display("FAIL flush_wait_next got %b %h want 1 00000077", wb_valid, wb_data);
    end
    tick();
  endtask

  task automatic test_backpressure;
    wb_ready = 1'b0;
    drive(mk(1'b0, 1'b0, MEM_WORD, 1'b0, 1'b1), 32'h0000_55AA, 32'h0, 32'h0000_0040);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({wb_valid, ex_ready} !== 2'b10 || wb_data !== 32'h0000_55AA || wb_pc !== 32'h0000_0040) begin
        errors++; $display("FAIL backpressure cyc%0d got %b %h %h want 10 000055aa 00000040", i, {wb_valid, ex_ready}, wb_data, wb_pc);
      end
      tick();
    end
    wb_ready = 1'b1;
    tick();
    checks++; if ({wb_valid, ex_ready} !== 2'b01) begin
      errors++; $display("FAIL backpressure_release got %b want 01", {wb_valid, ex_ready});
    end
  endtask

  task automatic test_flush_cases;
    drive(mk(1'b1, 1'b0, MEM_BYTE, 1'b0, 1'b1), 32'h0000_0104, 32'h0, 32'h0000_00B0);
    tick();
    ex_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if ({dmem_req, wb_valid, ex_ready} !== 3'b001) begin
      errors++; $display("FAIL flush_req got %b want 001", {dmem_req, wb_valid, ex_ready});
    end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    checks++; if ({dmem_req, wb_valid, ex_ready} !== 3'b001) begin
      errors++; $display("FAIL flush_late_gnt got %b want 001", {dmem_req, wb_valid, ex_ready});
    end
    drive(mk(1'b0, 1'b0, MEM_WORD, 1'b0, 1'b1), 32'h0000_0099, 32'h0, 32'h0000_00B4);
    flush = 1'b1;
    tick();
    ex_valid = 1'b0; flush = 1'b0;
    checks++; if ({wb_valid, ex_ready} !== 2'b01) begin
      errors++; $display("FAIL flush_transfer got %b want 01", {wb_valid, ex_ready});
    end
    wb_ready = 1'b0;
    drive(mk(1'b0, 1'b0, MEM_WORD, 1'b0, 1'b1), 32'h0000_0033, 32'h0, 32'h0000_00B8);
    tick();
    ex_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wb_ready = 1'b1;
    checks++; if ({wb_valid, ex_ready} !== 2'b01) begin
      errors++; $display("FAIL flush_out got %b want 01", {wb_valid, ex_ready});
    end
  endtask

  task automatic test_reset_in_req;
    drive(mk(1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0), 32'h0000_0200, 32'hDEAD_BEEF, 32'h0000_00C0);
    tick();
    ex_valid = 1'b0;
    checks++; if (dmem_req !== 1'b1 || dmem_be !== 4'b1111 || dmem_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL reset_req_pre got %b %b %h want 1 1111 deadbeef", dmem_req, dmem_be, dmem_wdata);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({dmem_req, dmem_we, wb_valid, misaligned, dmem_be} !== 8'h00 ||
                  {dmem_addr, dmem_wdata, wb_data, wb_pc} !== 128'h0) begin
      errors++; $display("FAIL reset_in_req got %b %h want 0", {dmem_req, dmem_we, wb_valid, misaligned, dmem_be},
                         {dmem_addr, dmem_wdata, wb_data, wb_pc});
    end
    #2 rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    checks++; if ({wb_valid, ex_ready} !== 2'b01) begin
      errors++; $display("FAIL late_rvalid got %b want 01", {wb_valid, ex_ready});
    end
  endtask

  task automatic test_misalign;
    drive(mk(1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1), 32'h0000_0102, 32'h0, 32'h0000_00D0);
    tick();
    ex_valid = 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    checks++; if ({dmem_req, wb_valid, misaligned, wb_control.reg_write} !== 4'b0110 || wb_data !== 32'h0000_0102) begin
      errors++; $display("FAIL misalign_trap got %b %h want 0110 00000102",
                         {dmem_req, wb_valid, misaligned, wb_control.reg_write}, wb_data);
    end
    tick();
    checks++; if ({wb_valid, misaligned} !== 2'b00) begin
      errors++; $display("FAIL misalign_retire got %b want 00", {wb_valid, misaligned});
    end
`else
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_0100 || dmem_be !== 4'b1111 || misaligned !== 1'b0) begin
      errors++; $display("FAIL misalign_masked got %b %h %b %b want 1 00000100 1111 0", dmem_req, dmem_addr, dmem_be, misaligned);
    end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h1234_5678 || misaligned !== 1'b0) begin
      errors++; $display("FAIL misalign_masked_wb got %b %h %b want 1 12345678 0", wb_valid, wb_data, misaligned);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_gnt_idle();
    test_store_byte();
    test_store_half();
    test_load(MEM_BYTE, 1'b1, 32'h0000_0102, 32'h0000_0100, 4'b0100, 32'h0080_0000, 32'hFFFF_FF80);
    test_load(MEM_BYTE, 1'b0, 32'h0000_0102, 32'h0000_0100, 4'b0100, 32'h0080_0000, 32'h0000_0080);
    test_load(MEM_HALF, 1'b1, 32'h0000_0102, 32'h0000_0100, 4'b1100, 32'h8001_0000, 32'hFFFF_8001);
    test_load(MEM_HALF, 1'b0, 32'h0000_0300, 32'h0000_0300, 4'b0011, 32'h0000_9ABC, 32'h0000_9ABC);
    test_load(MEM_WORD, 1'b0, 32'h0000_0200, 32'h0000_0200, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D);
    test_flush_wait_r();
    test_backpressure();
    test_flush_cases();
    test_misalign();
    test_reset_in_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 ex_valid  in  1  execution-stage result valid this cycle.
REQ-004 ex_ready  out  1  stage accepts a new operation this cycle.
REQ-005 control_in  in  common::control_type  decoded control; uses mem_read, mem_write, mem_size, mem_sign, reg_write, mem_to_reg.
REQ-006 alu_data  in  32  ALU result; also the load/store byte address.
REQ-007 memory_data  in  32  store data (rs2).
REQ-008 program_counter  in  32  PC of the instruction.
REQ-009 flush  in  1  synchronous squash of the held operation.
REQ-010 dmem_req / dmem_we  out  1/1  memory request and write enable.
REQ-011 dmem_addr / dmem_wdata / dmem_be  out  32/32/4  word-aligned address, lane-replicated data, byte enables.
REQ-012 dmem_gnt / dmem_rvalid  in  1/1  request accepted; read data valid.
REQ-013 dmem_rdata  in  32  read data.
REQ-014 wb_valid  out  1  writeback payload valid.
REQ-015 wb_ready  in  1  writeback consumes payload.
REQ-016 wb_control / wb_data / wb_pc  out  control_type/32/32  forwarded control, result (load data or alu_data), PC.
REQ-017 misaligned  out  1  qualifies wb_valid; misaligned access.

Function
REQ-018 States: IDLE, REQ, WAIT_R, OUT; exactly one active.
REQ-019 ex_ready SHALL be 1 only in IDLE; transfer = ex_valid && ex_ready.
REQ-020 Non-memory op: IDLE->OUT; wb_valid rises the cycle after transfer; wb_data = alu_data.
REQ-021 Memory op: IDLE->REQ; dmem_req=1 from the next cycle, held with stable addr/we/be/wdata until dmem_gnt.
REQ-022 On gnt: store -> OUT; load -> WAIT_R. rvalid in the gnt cycle SHALL NOT be sampled.
REQ-023 WAIT_R: on dmem_rvalid, capture extracted data and go to OUT.
REQ-024 OUT: wb_valid=1 and payload stable until wb_ready; then IDLE. No new accept in the same cycle.
REQ-025 dmem_addr = {alu_data[31:2],2'b00}. Byte: be=0001<<a[1:0], wdata=4x byte. Half: be=0011<<a[1:0], wdata=2x half. Word: be=1111.
REQ-026 Load extract: select byte/half by a[1:0]; sign-extend when mem_sign=1, else zero-extend.
REQ-027 flush in REQ before gnt: drop the request, go to IDLE next cycle, no wb_valid.
REQ-028 flush in WAIT_R: keep waiting for rvalid, discard the data, then go to IDLE.
REQ-029 flush in OUT: drop the payload and go to IDLE. flush in IDLE has no effect; flush in the same cycle as a transfer wins and nothing is accepted.
REQ-030 A gnt that arrives while dmem_req=0 SHALL be ignored.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE; dmem_req, dmem_we, wb_valid and misaligned are 0; dmem_addr, dmem_wdata, wb_data and wb_pc are 0; dmem_be=0; wb_control=all-zero.
REQ-032 Reset mid-transaction abandons it; a late rvalid in IDLE SHALL be ignored.

Configuration
REQ-033 Macro MEM_STAGE_MISALIGN_CHECK_EN defined: a half access with a[0]=1, or a word access with a[1:0]!=0, is never issued. The block goes IDLE->OUT with misaligned=1 and wb_control.reg_write forced to 0.
REQ-034 Macro undefined: misaligned=0 always. Low address bits are masked per size: half uses a[1], word uses 0.

Structure
REQ-035 Package common SHALL hold control_type, the mem_size encodings (BYTE=0, HALF=1, WORD=2) and the stage state enum.
REQ-036 The load-extract/store-align logic SHALL be a combinational sub-module mem_lane_align.

Verification
REQ-037 Non-memory op, alu_data=0x1234, wb_ready=1 -> wb_valid one cycle after transfer, wb_data=0x1234, dmem_req never asserted.
REQ-038 Store byte, addr 0x103, data 0xAB, gnt after 3 cycles -> dmem_addr=0x100, be=1000, wdata=0xABABABAB held 3 cycles, then wb_valid.
REQ-039 Signed byte load, addr 0x102, rdata=0x00800000, rvalid 2 cycles after gnt -> wb_data=0xFFFFFF80. Same with mem_sign=0 -> 0x00000080.
REQ-040 Load in WAIT_R with flush pulsed -> no wb_valid. The next op is accepted only after rvalid returns.
REQ-041 wb_ready=0 for 5 cycles in OUT -> payload stable, ex_ready=0. Reset in REQ -> all outputs 0 immediately.
REQ-042 MEM_STAGE_MISALIGN_CHECK_EN, word load at 0x102 -> no dmem_req, wb_valid with misaligned=1, reg_write=0.
